// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared constants and types for the AES-GCM datapath.
//   Round counts for each AES key size, the round-counter width and the
//   matching round-number type.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned AES128_ROUNDS = 10;
    localparam int unsigned AES192_ROUNDS = 12;
    localparam int unsigned AES256_ROUNDS = 14;

    localparam int unsigned RND_CNT_W = 4;

    typedef logic [RND_CNT_W-1:0] rnd_cnt_t;

endpackage : aes_pkg

// File: rtl/aes_round_counter.sv
// ---------------------------------------------------------------------------
// aes_round_counter
//   Round counter for the AES datapath of the AES-GCM core. While enabled it
//   counts 0,1,...,MAX_CNT and then wraps to 0. o_flag marks the final round
//   so the round controller can pick the last-round transform.
//
// Parameters
//   MAX_CNT   terminal count (number of rounds), 1 .. 2**CNT_SIZE-1
//   CNT_SIZE  counter width in bits
//
// Ports
//   clk        in   1         rising-edge clock
//   rst_n      in   1         synchronous, active-low reset (top priority)
//   i_cnt_clr  in   1         synchronous clear (only with AES_RND_CNT_CLR_EN)
//   i_cnt_en   in   1         advance one step per cycle while high
//   o_flag     out  1         high while o_count == MAX_CNT
//   o_count    out  CNT_SIZE  current round number
//
// Build option
//   AES_RND_CNT_CLR_EN  when defined, adds the i_cnt_clr port. Without it the
//                       counter clears only through reset or wrap.
// ---------------------------------------------------------------------------
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int unsigned MAX_CNT  = AES128_ROUNDS,
    parameter int unsigned CNT_SIZE = RND_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef AES_RND_CNT_CLR_EN
    input  logic                i_cnt_clr,
`endif
    input  logic                i_cnt_en,
    output logic                o_flag,
    output logic [CNT_SIZE-1:0] o_count
);

    localparam logic [CNT_SIZE-1:0] LP_MAX  = CNT_SIZE'(MAX_CNT);
    localparam logic [CNT_SIZE-1:0] LP_ONE  = CNT_SIZE'(1);
    localparam logic [CNT_SIZE-1:0] LP_ZERO = '0;

    // Elaboration-time legality of the MAX_CNT / CNT_SIZE pair.
    generate
        if (CNT_SIZE < 1 || CNT_SIZE > 31) begin : g_bad_width
            $fatal(1, "aes_round_counter: CNT_SIZE=%0d out of range 1..31", CNT_SIZE);
        end
        else if (MAX_CNT < 1 || MAX_CNT >= (32'd1 << CNT_SIZE)) begin : g_bad_max
            $fatal(1, "aes_round_counter: MAX_CNT=%0d illegal for CNT_SIZE=%0d",
                   MAX_CNT, CNT_SIZE);
        end
    endgenerate

    logic                r_count;
    logic [CNT_SIZE-1:0] r_cnt;
    logic [CNT_SIZE-1:0] w_cnt_nxt;
    logic                w_clr;

`ifdef AES_RND_CNT_CLR_EN
    assign w_clr = i_cnt_clr;
`else
    assign w_clr = 1'b0;
`endif

    // ">=" rather than "==" so an unreachable value above MAX_CNT (e.g. an
    // upset) recovers to 0 on the next enabled edge.
    always_comb begin
        w_cnt_nxt = r_cnt + LP_ONE;
        if (r_cnt >= LP_MAX) begin
            w_cnt_nxt = LP_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= LP_ZERO;
        end
        else if (w_clr) begin
            r_cnt <= LP_ZERO;
        end
        else if (i_cnt_en) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Unused single-bit alias kept tied off to avoid a dangling declaration.
    assign r_count = 1'b0;

    assign o_count = r_cnt;
    assign o_flag  = (r_cnt == LP_MAX);

`ifndef SYNTHESIS
    a_cnt_in_range : assert property (@(posedge clk) disable iff (!rst_n)
        r_cnt <= LP_MAX)
        else $error("aes_round_counter: count %0d above MAX_CNT", r_cnt);

    a_flag_match : assert property (@(posedge clk) disable iff (!rst_n)
        o_flag == (o_count == LP_MAX))
        else $error("aes_round_counter: o_flag inconsistent with o_count");
`endif

endmodule : aes_round_counter

// File: tb/tb_aes_round_counter.sv
// ---------------------------------------------------------------------------
// tb_aes_round_counter
//   Directed bench for aes_round_counter (default MAX_CNT=10, CNT_SIZE=4).
//   Each step drives inputs, pushes the expected post-edge count onto a
//   scoreboard queue, then after the edge pops it and compares.
//   Build option AES_RND_CNT_CLR_EN enables the synchronous-clear steps.
// ---------------------------------------------------------------------------
module tb_aes_round_counter;

    localparam int unsigned MAX = 10;

    logic       clk;
    logic       rst_n;
    logic       cnt_clr;
    logic       cnt_en;
    logic       flag;
    logic [3:0] count;

    int checks;
    int errors;

    logic [3:0] sb_q[$];
    logic [3:0] mdl;

    aes_round_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef AES_RND_CNT_CLR_EN
        .i_cnt_clr(cnt_clr),
`endif
        .i_cnt_en (cnt_en),
        .o_flag   (flag),
        .o_count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_cnt(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: count observed %0d expected %0d", tag, obs, exp);
            $error("%s count obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flag(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: flag observed %0b expected %0b", tag, obs, exp);
            $error("%s flag obs=%0b exp=%0b", tag, obs, exp);
        end
    endtask

    // One clock: drive, predict, edge, pop and compare.
    task automatic step(input string tag, input logic r, input logic en, input logic clr);
        logic [3:0] exp;
        rst_n   = r;
        cnt_en  = en;
        cnt_clr = clr;
        if (!r)                          mdl = 4'd0;
`ifdef AES_RND_CNT_CLR_EN
        else if (clr)                    mdl = 4'd0;
`endif
        else if (en) mdl = (mdl == 4'(MAX)) ? 4'd0 : mdl + 4'd1;
        sb_q.push_back(mdl);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end
        else begin
            exp = sb_q.pop_front();
            chk_cnt(tag, count, exp);
            chk_flag(tag, flag, exp == 4'(MAX));
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        mdl     = 4'd0;
        rst_n   = 1'b0;
        cnt_en  = 1'b1;
        cnt_clr = 1'b0;

        // 1: reset held with enable high
        for (int i = 0; i < 5; i++) step("reset", 1'b0, 1'b1, 1'b0);
        chk_cnt("reset_lit", count, 4'd0);
        chk_flag("reset_lit", flag, 1'b0);

        // 2: full run 0..10
        for (int i = 0; i < 10; i++) step("run", 1'b1, 1'b1, 1'b0);
        chk_cnt("run_end_lit", count, 4'd10);
        chk_flag("run_end_lit", flag, 1'b1);

        // 3: wrap to 0 then keep counting to 4
        step("wrap", 1'b1, 1'b1, 1'b0);
        chk_cnt("wrap_lit", count, 4'd0);
        chk_flag("wrap_lit", flag, 1'b0);
        for (int i = 0; i < 4; i++) step("post_wrap", 1'b1, 1'b1, 1'b0);
        chk_cnt("at4_lit", count, 4'd4);

        // 4: hold at 4 for 3 cycles, then resume
        for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b0, 1'b0);
        chk_cnt("hold_lit", count, 4'd4);
        step("resume", 1'b1, 1'b1, 1'b0);
        chk_cnt("resume_lit", count, 4'd5);

        // 5: reset mid-run at 7
        step("to7", 1'b1, 1'b1, 1'b0);
        step("to7", 1'b1, 1'b1, 1'b0);
        chk_cnt("at7_lit", count, 4'd7);
        step("mid_rst", 1'b0, 1'b0, 1'b0);
        chk_cnt("mid_rst_lit", count, 4'd0);
        step("restart", 1'b1, 1'b1, 1'b0);
        chk_cnt("restart_lit", count, 4'd1);

        // Enable low at MAX_CNT: flag stays high until next enabled edge
        for (int i = 0; i < 9; i++) step("to_max", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("hold_max", 1'b1, 1'b0, 1'b0);
        chk_cnt("hold_max_lit", count, 4'd10);
        chk_flag("hold_max_lit", flag, 1'b1);
        step("wrap_late", 1'b1, 1'b1, 1'b0);
        chk_flag("wrap_late_lit", flag, 1'b0);

`ifdef AES_RND_CNT_CLR_EN
        // 6: synchronous clear beats enable
        for (int i = 0; i < 6; i++) step("to6", 1'b1, 1'b1, 1'b0);
        chk_cnt("at6_lit", count, 4'd6);
        step("clr", 1'b1, 1'b1, 1'b1);
        chk_cnt("clr_lit", count, 4'd0);
        step("after_clr", 1'b1, 1'b1, 1'b0);
        chk_cnt("after_clr_lit", count, 4'd1);
`endif

        // Sustained run across two wraps
        for (int i = 0; i < 24; i++) step("long", 1'b1, 1'b1, 1'b0);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_aes_round_counter
